// File: rtl/lab3_converter_state_diagram.sv
// Serial Excess-3 to BCD converter (Mealy FSM).
// One digit = four cycles, LSB first; the machine subtracts 0011 bit by bit
// with a ripple borrow carried in the state, and wraps back to bit0 with no
// gap cycle. Invalid codes still yield (code - 3) mod 16, with the final
// borrow dropped.
// Optional build macro: CONV_ERR_EN adds the Err output, which flags
// codes outside 0011..1100 during the bit3 cycle.
module lab3_converter_state_diagram (
    input  logic Clk,
    input  logic Rst,
    input  logic X,
    output logic Z
`ifdef CONV_ERR_EN
    ,
    output logic Err
`endif
);

    // S0 = bit0; odd states = no borrow pending, even states (S2/S4/S6) = borrow pending
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } state_t;

    state_t state, next_state;

    // State register; synchronous reset restarts at bit0 of a new digit
    always_ff @(posedge Clk) begin
        if (Rst) state <= S0;
        else     state <= next_state;
    end

    // Next-state and Mealy output; the unused encoding falls back to S0 with Z=0
    always_comb begin
        next_state = S0;
        Z          = 1'b0;
        case (state)
            S0: begin
                Z          = ~X;
                next_state = X ? S1 : S2;
            end
            S1: begin
                Z          = ~X;
                next_state = X ? S3 : S4;
            end
            S2: begin
                Z          = X;
                next_state = S4;
            end
            S3: begin
                Z          = X;
                next_state = S5;
            end
            S4: begin
                Z          = ~X;
                next_state = X ? S5 : S6;
            end
            S5: begin
                Z          = X;
                next_state = S0;
            end
            S6: begin
                Z          = ~X;
                next_state = S0;
            end
            default: begin
                Z          = 1'b0;
                next_state = S0;
            end
        endcase
        if (Rst) Z = 1'b0;
    end

`ifdef CONV_ERR_EN
    // Last three input bits; in the bit3 cycle this holds {b2, b1, b0}
    logic [2:0] hist;
    logic [3:0] code;

    // Shift in each incoming bit so the full code is visible on bit3
    always_ff @(posedge Clk) begin
        if (Rst) hist <= 3'b000;
        else     hist <= {X, hist[2:1]};
    end

    // Flag codes outside 3..12, only while the bit3 cycle is on the wire
    always_comb begin
        code = {X, hist};
        Err  = 1'b0;
        if (!Rst && (state == S5 || state == S6))
            Err = (code < 4'd3) || (code > 4'd12);
    end
`endif

endmodule

// File: tb/tb_lab3_converter_state_diagram.sv
// Bench for the serial Excess-3 to BCD converter.
// Reference: each digit's expected BCD is simply (code - 3) mod 16, and
// Err (when built in) is expected only on bit3 of a code outside 3..12.
module tb_lab3_converter_state_diagram;

    logic Clk = 1'b0;
    logic Rst;
    logic X;
    logic Z;
`ifdef CONV_ERR_EN
    logic Err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    lab3_converter_state_diagram dut (
        .Clk (Clk),
        .Rst (Rst),
        .X   (X),
        .Z   (Z)
`ifdef CONV_ERR_EN
        ,
        .Err (Err)
`endif
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold Rst for a number of cycles with random X; Z (and Err) must stay 0.
    // Returns at posedge+1 with Rst low, so the next cycle is bit0.
    task automatic do_reset(input int cycles);
        Rst = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            X = 1'($urandom);
            @(negedge Clk);
            check("rst_z", {3'b000, Z}, 4'h0);
`ifdef CONV_ERR_EN
            check("rst_err", {3'b000, Err}, 4'h0);
`endif
            @(posedge Clk);
            #1;
        end
        Rst = 1'b0;
    endtask

    // Send one 4-bit code LSB first; check each Z bit and the assembled BCD.
    task automatic send_digit(input string tag, input logic [3:0] code);
        logic [3:0] exp;
        logic [3:0] bcd;
        logic       exp_err;
        exp = 4'(code - 4'd3);
        bcd = 4'h0;
        for (int i = 0; i < 4; i++) begin
            X = code[i];
            @(negedge Clk);
            bcd[i] = Z;
            check({tag, "_zbit"}, {3'b000, Z}, {3'b000, exp[i]});
            exp_err = (i == 3) && ((code < 4'd3) || (code > 4'd12));
`ifdef CONV_ERR_EN
            check({tag, "_err"}, {3'b000, Err}, {3'b000, exp_err});
`else
            exp_err = 1'b0;
`endif
            @(posedge Clk);
            #1;
        end
        check({tag, "_bcd"}, bcd, exp);
    endtask

    initial begin
        Rst = 1'b1;
        X   = 1'b0;
        do_reset(2);

        // Smallest valid code 0011 -> BCD 0000
        send_digit("d3", 4'b0011);
        // Largest valid code 1100 -> BCD 1001
        send_digit("d12", 4'b1100);
        // Back-to-back digits, no idle cycle
        send_digit("d7", 4'b0111);
        send_digit("d8", 4'b1000);

        // Abandon a digit after two bits, then a fresh digit must start at bit0
        X = 1'b1;
        @(posedge Clk); #1;
        X = 1'b0;
        @(posedge Clk); #1;
        do_reset(2);
        send_digit("d5", 4'b0101);

        // Every code, including the invalid ones, wraps to code-3 mod 16
        for (int c = 0; c < 16; c++) send_digit("all", 4'(c));

`ifdef CONV_ERR_EN
        send_digit("err1", 4'b0001);
        send_digit("err9", 4'b1001);
`endif

        // Random valid digits, streamed without gaps
        for (int n = 0; n < 10000; n++)
            send_digit("rand", 4'($urandom_range(12, 3)));

        // Mid-stream reset once more, with a random partial digit
        X = 1'($urandom);
        @(posedge Clk); #1;
        do_reset(1);
        send_digit("post", 4'b1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
